// File: rtl/oh_cdc_pkg.sv
// Shared definitions for the CDC handshake controller and its synchronizer.
package oh_cdc_pkg;

    // Handshake controller states.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        REL  = 2'b10
    } hs_state_t;

    // A TMAX of this value turns the timeout detector off.
    localparam int unsigned TMAX_DISABLED = 0;

endpackage

// File: rtl/oh_dsync.sv
// Multi-stage level synchronizer with synchronous active-low reset.
// PS flops in series. A non-zero DELAY adds one more flop on the output.
module oh_dsync #(
    parameter int unsigned PS    = 2,
    parameter int unsigned DELAY = 0
) (
    input  logic clk,
    input  logic nreset,
    input  logic din,
    output logic dout
);

    logic [PS-1:0] r_pipe;

    // Shift the asynchronous input through the synchronizer chain.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_pipe <= '0;
        end else begin
            r_pipe <= {r_pipe[PS-2:0], din};
        end
    end

    generate
        if (DELAY != 0) begin : g_delay
            logic r_dly;

            // Optional extra retiming stage after the synchronizer.
            always_ff @(posedge clk) begin
                if (!nreset) begin
                    r_dly <= 1'b0;
                end else begin
                    r_dly <= r_pipe[PS-1];
                end
            end

            assign dout = r_dly;
        end else begin : g_nodelay
            assign dout = r_pipe[PS-1];
        end
    endgenerate

endmodule

// File: rtl/oh_cdc_hs_ctrl.sv
// Source-side 4-phase req/ack controller. It captures a producer word,
// holds it on data_out and handshakes it into another clock domain.
// There is also an optional sticky timeout on a stalled handshake.
module oh_cdc_hs_ctrl
    import oh_cdc_pkg::*;
#(
    parameter int unsigned DW   = 32,
    parameter int unsigned PS   = 2,
    parameter int unsigned TW   = 16,
    parameter int unsigned TMAX = 0
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          valid_in,
    input  logic [DW-1:0] data_in,
    output logic          ready_out,
    output logic          req_out,
    output logic [DW-1:0] data_out,
    input  logic          ack_in,
    output logic          done,
    output logic          busy,
    output logic          timeout,
    input  logic          clr_err
);

    localparam logic [TW-1:0] TMAX_C = TW'(TMAX);

    hs_state_t     r_state;
    hs_state_t     w_state_nxt;
    logic          w_ack_s;
    logic          w_accept;
    logic          w_state_chg;
    logic          w_tmo_evt;
    logic          r_req;
    logic          r_done;
    logic          r_timeout;
    logic [DW-1:0] r_data;
    logic [TW-1:0] r_cnt;
    logic [TW-1:0] w_cnt_nxt;

    oh_dsync #(
        .PS    (PS),
        .DELAY (0)
    ) u_ack_sync (
        .clk    (clk),
        .nreset (nreset),
        .din    (ack_in),
        .dout   (w_ack_s)
    );

    // A stale synchronized ack blocks acceptance until it clears.
    assign w_accept    = (r_state == IDLE) && valid_in && !w_ack_s;
    assign w_state_chg = (w_state_nxt != r_state);

    // State register, plus req/done registered from the next-state decode.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= (w_state_nxt == REQ);
            r_done  <= (r_state == REL) && (w_state_nxt == IDLE);
        end
    end

    // Next-state logic for the REQ -> REL -> IDLE handshake sequence.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_accept) w_state_nxt = REQ;
            REQ:  if (w_ack_s)  w_state_nxt = REL;
            REL:  if (!w_ack_s) w_state_nxt = IDLE;
            default:            w_state_nxt = IDLE;
        endcase
    end

    // Output decode.
    always_comb begin
        ready_out = (r_state == IDLE) && !w_ack_s;
        busy      = (r_state != IDLE);
        req_out   = r_req;
        done      = r_done;
        data_out  = r_data;
        timeout   = r_timeout;
    end

    // Capture the producer word on acceptance. It is frozen otherwise.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_data <= '0;
        end else if (w_accept) begin
            r_data <= data_in;
        end
    end

    // Wait counter: cleared on each state change. Counts and saturates while busy.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_state_chg) begin
            w_cnt_nxt = '0;
        end else if ((r_state != IDLE) && (r_cnt != '1)) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    // Timeout event is the single cycle in which the counter arrives at TMAX.
    assign w_tmo_evt = (TMAX != TMAX_DISABLED) && (w_cnt_nxt == TMAX_C) && (r_cnt != TMAX_C);

    // Register the wait counter.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    // Sticky timeout flag. A new event takes priority over clr_err.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_timeout <= 1'b0;
        end else if (w_tmo_evt) begin
            r_timeout <= 1'b1;
        end else if (clr_err) begin
            r_timeout <= 1'b0;
        end
    end

endmodule
